// File: rtl/vc_pkg.sv
// vc_pkg: shared definitions for the VC pop arbiter slice.
//   - vc_state_e : FSM state encodings (3 bits), exported on the arbiter's state port.
//   - DATA_SIZE_DEF / DEST_BIT_DEF : default word width and destination-select bit.
package vc_pkg;

    localparam int unsigned STATE_W       = 3;
    localparam int unsigned DATA_SIZE_DEF = 6;
    localparam int unsigned DEST_BIT_DEF  = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } vc_state_e;

endpackage

// File: rtl/vc_dest_router.sv
// vc_dest_router: selects the word returned by the popped VC FIFO and steers it to
// destination D0 or D1 according to its destination bit.
// Ports:
//   valid_i     - a word popped last cycle is on the data inputs now
//   sel_i       - 0: word comes from VC0, 1: from VC1
//   block_i     - suppress all pushes (arbiter is in ERROR)
//   data_vc0_i  - VC0 registered pop data
//   data_vc1_i  - VC1 registered pop data
//   push_d0_o   - push to destination D0
//   push_d1_o   - push to destination D1
//   data_d0_o   - word to D0, zero when not pushing
//   data_d1_o   - word to D1, zero when not pushing
module vc_dest_router
    import vc_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
    parameter int unsigned DEST_BIT  = DEST_BIT_DEF
) (
    input  logic                 valid_i,
    input  logic                 sel_i,
    input  logic                 block_i,
    input  logic [DATA_SIZE-1:0] data_vc0_i,
    input  logic [DATA_SIZE-1:0] data_vc1_i,
    output logic                 push_d0_o,
    output logic                 push_d1_o,
    output logic [DATA_SIZE-1:0] data_d0_o,
    output logic [DATA_SIZE-1:0] data_d1_o
);

    logic [DATA_SIZE-1:0] word;
    logic                 go;

    always_comb begin
        word      = sel_i ? data_vc1_i : data_vc0_i;
        go        = valid_i && !block_i;
        push_d0_o = go && !word[DEST_BIT];
        push_d1_o = go &&  word[DEST_BIT];
        // Zeroed data keeps the destination buses quiet between pushes.
        data_d0_o = push_d0_o ? word : '0;
        data_d1_o = push_d1_o ? word : '0;
    end

endmodule

// File: rtl/vc_pop_arbiter.sv
// vc_pop_arbiter: read-side controller for the two virtual-channel FIFOs.
// Pops VC0 with fixed priority over VC1, forwards each word one cycle later to D0 or D1,
// halts popping while either destination is almost full and freezes on any FIFO error.
// Ports:
//   clk, reset_L           - clock (rising edge), asynchronous active-low reset
//   init                   - synchronous re-initialisation request
//   fifo_empty_vc0/vc1     - VC FIFO empty flags
//   data_vc0_in/vc1_in     - VC FIFO registered pop data (valid the cycle after a pop)
//   fifo_pause_d0/d1       - destination almost-full flags
//   fifo_error_any         - OR of all FIFO error flags
//   pop_vc0/vc1            - pop requests to the VC FIFOs
//   push_d0/d1, data_d0/d1 - push requests and data to the destination FIFOs
//   state, idle            - FSM state and IDLE indicator
//   pkt_count              - words pushed since reset/INIT, wrapping
module vc_pop_arbiter
    import vc_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
    parameter int unsigned DEST_BIT  = DEST_BIT_DEF,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 init,
    input  logic                 fifo_empty_vc0,
    input  logic                 fifo_empty_vc1,
    input  logic [DATA_SIZE-1:0] data_vc0_in,
    input  logic [DATA_SIZE-1:0] data_vc1_in,
    input  logic                 fifo_pause_d0,
    input  logic                 fifo_pause_d1,
    input  logic                 fifo_error_any,
    output logic                 pop_vc0,
    output logic                 pop_vc1,
    output logic                 push_d0,
    output logic                 push_d1,
    output logic [DATA_SIZE-1:0] data_d0,
    output logic [DATA_SIZE-1:0] data_d1,
    output logic [2:0]           state,
    output logic                 idle,
    output logic [CNT_WIDTH-1:0] pkt_count
);

    vc_state_e            state_q, state_d;
    logic                 valid_q, valid_d;
    logic                 sel_q, sel_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 pop_en;
    logic                 flush;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_RESET) begin
            state_d = ST_INIT;
        end else if (init) begin
            // init outranks a simultaneous error
            state_d = ST_INIT;
        end else if (fifo_error_any) begin
            state_d = ST_ERROR;
        end else begin
            case (state_q)
                ST_INIT:   state_d = ST_IDLE;
                ST_IDLE:   if (!fifo_empty_vc0 || !fifo_empty_vc1) state_d = ST_ACTIVE;
                ST_ACTIVE: if (fifo_empty_vc0 && fifo_empty_vc1 && !valid_q) state_d = ST_IDLE;
                ST_ERROR:  state_d = ST_ERROR;
                // Unused encodings are treated as a fault.
                default:   state_d = ST_ERROR;
            endcase
        end
    end

    // ---------------- Pop logic ----------------
    always_comb begin
        pop_en  = (state_q == ST_ACTIVE) && !fifo_pause_d0 && !fifo_pause_d1;
        pop_vc0 = pop_en && !fifo_empty_vc0;
        pop_vc1 = pop_en && fifo_empty_vc0 && !fifo_empty_vc1;
    end

    // ---------------- Pipeline registers ----------------
    always_comb begin
        flush   = (state_q == ST_RESET) || (state_q == ST_INIT) || (state_q == ST_ERROR);
        valid_d = flush ? 1'b0 : (pop_vc0 || pop_vc1);
        sel_d   = flush ? 1'b0 : pop_vc1;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            valid_q <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            sel_q   <= sel_d;
        end
    end

    // ---------------- Routing ----------------
    vc_dest_router #(
        .DATA_SIZE (DATA_SIZE),
        .DEST_BIT  (DEST_BIT)
    ) u_router (
        .valid_i    (valid_q),
        .sel_i      (sel_q),
        .block_i    (state_q == ST_ERROR),
        .data_vc0_i (data_vc0_in),
        .data_vc1_i (data_vc1_in),
        .push_d0_o  (push_d0),
        .push_d1_o  (push_d1),
        .data_d0_o  (data_d0),
        .data_d1_o  (data_d1)
    );

    // ---------------- Forwarded-word counter ----------------
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = '0;
        end else if (push_d0 || push_d1) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign state     = state_q;
    assign idle      = (state_q == ST_IDLE);
    assign pkt_count = cnt_q;

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// tb_vc_pop_arbiter: directed bench for vc_pop_arbiter. Two small array-backed FIFO models
// supply the VC side (data registered on the pop edge, empty flag follows the read pointer).
module tb_vc_pop_arbiter;

    logic       clk;
    logic       reset_L;
    logic       init;
    logic       fifo_empty_vc0;
    logic       fifo_empty_vc1;
    logic [5:0] data_vc0_in = '0;
    logic [5:0] data_vc1_in = '0;
    logic       fifo_pause_d0;
    logic       fifo_pause_d1;
    logic       fifo_error_any;
    logic       pop_vc0;
    logic       pop_vc1;
    logic       push_d0;
    logic       push_d1;
    logic [5:0] data_d0;
    logic [5:0] data_d1;
    logic [2:0] state;
    logic       idle;
    logic [7:0] pkt_count;

    int passed = 0;
    int total  = 0;

    // VC FIFO models
    logic [5:0] mem0 [0:511];
    logic [5:0] mem1 [0:511];
    int wr0 = 0;
    int wr1 = 0;
    int rd0 = 0;
    int rd1 = 0;

    assign fifo_empty_vc0 = (rd0 == wr0);
    assign fifo_empty_vc1 = (rd1 == wr1);

    always @(posedge clk) begin
        if (pop_vc0) begin
            data_vc0_in <= mem0[rd0];
            rd0         <= rd0 + 1;
        end
        if (pop_vc1) begin
            data_vc1_in <= mem1[rd1];
            rd1         <= rd1 + 1;
        end
    end

    vc_pop_arbiter #(
        .DATA_SIZE (6),
        .DEST_BIT  (4),
        .CNT_WIDTH (8)
    ) dut (
        .clk            (clk),
        .reset_L        (reset_L),
        .init           (init),
        .fifo_empty_vc0 (fifo_empty_vc0),
        .fifo_empty_vc1 (fifo_empty_vc1),
        .data_vc0_in    (data_vc0_in),
        .data_vc1_in    (data_vc1_in),
        .fifo_pause_d0  (fifo_pause_d0),
        .fifo_pause_d1  (fifo_pause_d1),
        .fifo_error_any (fifo_error_any),
        .pop_vc0        (pop_vc0),
        .pop_vc1        (pop_vc1),
        .push_d0        (push_d0),
        .push_d1        (push_d1),
        .data_d0        (data_d0),
        .data_d1        (data_d1),
        .state          (state),
        .idle           (idle),
        .pkt_count      (pkt_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance to just after the next falling edge.
    task automatic next();
        @(negedge clk);
        #1;
    endtask

    task automatic load0(input logic [5:0] w);
        mem0[wr0] = w;
        wr0++;
    endtask

    task automatic load1(input logic [5:0] w);
        mem1[wr1] = w;
        wr1++;
    endtask

    int n_d0;
    int n_d1;
    int bad_data;
    int exp_i;
    logic done;

    initial begin
        reset_L        = 1'b0;
        init           = 1'b0;
        fifo_pause_d0  = 1'b0;
        fifo_pause_d1  = 1'b0;
        fifo_error_any = 1'b0;

        // ---- Reset values ----
        next();
        chk("rst_state", 32'(state), 0);
        chk("rst_idle", 32'(idle), 0);
        chk("rst_pop0", 32'(pop_vc0), 0);
        chk("rst_push0", 32'(push_d0), 0);
        chk("rst_pkt", 32'(pkt_count), 0);
        reset_L = 1'b1;
        next();
        chk("rel_init", 32'(state), 1);
        next();
        chk("rel_idle_state", 32'(state), 2);
        chk("rel_idle", 32'(idle), 1);

        // ---- Priority: VC0 = 05,15 ; VC1 = 03 ----
        load0(6'h05);
        load0(6'h15);
        load1(6'h03);
        #1;
        chk("pri_idle_nopop0", 32'(pop_vc0), 0);
        chk("pri_idle_nopop1", 32'(pop_vc1), 0);
        next();
        chk("pri_active", 32'(state), 3);
        chk("pri_c1_pop0", 32'(pop_vc0), 1);
        chk("pri_c1_pop1", 32'(pop_vc1), 0);
        chk("pri_c1_push0", 32'(push_d0), 0);
        chk("pri_c1_push1", 32'(push_d1), 0);
        next();
        chk("pri_c2_pop0", 32'(pop_vc0), 1);
        chk("pri_c2_push0", 32'(push_d0), 1);
        chk("pri_c2_data0", 32'(data_d0), 32'h05);
        chk("pri_c2_data1", 32'(data_d1), 0);
        next();
        chk("pri_c3_pop0", 32'(pop_vc0), 0);
        chk("pri_c3_pop1", 32'(pop_vc1), 1);
        chk("pri_c3_push1", 32'(push_d1), 1);
        chk("pri_c3_push0", 32'(push_d0), 0);
        chk("pri_c3_data1", 32'(data_d1), 32'h15);
        next();
        chk("pri_c4_pop1", 32'(pop_vc1), 0);
        chk("pri_c4_push0", 32'(push_d0), 1);
        chk("pri_c4_data0", 32'(data_d0), 32'h03);
        chk("pri_c4_pkt", 32'(pkt_count), 2);
        // ---- Drain: state holds ACTIVE until valid_q has cleared ----
        chk("drain_inflight_state", 32'(state), 3);
        next();
        chk("drain_push0", 32'(push_d0), 0);
        chk("pri_pkt", 32'(pkt_count), 3);
        chk("drain_last_active", 32'(state), 3);
        next();
        chk("drain_idle", 32'(state), 2);
        chk("drain_idle_flag", 32'(idle), 1);

        // ---- Pause: VC0 = 11,02,13,04 ----
        load0(6'h11);
        load0(6'h02);
        load0(6'h13);
        load0(6'h04);
        next();
        chk("pau_active", 32'(state), 3);
        chk("pau_pop_a", 32'(pop_vc0), 1);
        next();
        chk("pau_pop_b", 32'(pop_vc0), 1);
        fifo_pause_d1 = 1'b1;
        #1;
        chk("pau_pop_blocked", 32'(pop_vc0), 0);
        chk("pau_inflight_push1", 32'(push_d1), 1);
        chk("pau_inflight_data1", 32'(data_d1), 32'h11);
        next();
        chk("pau_hold_pop", 32'(pop_vc0), 0);
        chk("pau_hold_push0", 32'(push_d0), 0);
        chk("pau_hold_push1", 32'(push_d1), 0);
        chk("pau_hold_pkt", 32'(pkt_count), 4);
        next();
        chk("pau_hold2_pop", 32'(pop_vc0), 0);
        chk("pau_hold2_state", 32'(state), 3);
        fifo_pause_d1 = 1'b0;
        #1;
        chk("pau_resume_pop", 32'(pop_vc0), 1);
        next();
        chk("pau_w2_push0", 32'(push_d0), 1);
        chk("pau_w2_data0", 32'(data_d0), 32'h02);
        next();
        chk("pau_w3_push1", 32'(push_d1), 1);
        chk("pau_w3_data1", 32'(data_d1), 32'h13);
        next();
        chk("pau_w4_push0", 32'(push_d0), 1);
        chk("pau_w4_data0", 32'(data_d0), 32'h04);
        chk("pau_w4_nopop", 32'(pop_vc0), 0);
        next();
        chk("pau_pkt", 32'(pkt_count), 7);
        chk("pau_end_push0", 32'(push_d0), 0);
        next();
        chk("pau_idle", 32'(state), 2);

        // ---- Error: VC0 = 06,07,08 ----
        load0(6'h06);
        load0(6'h07);
        load0(6'h08);
        next();
        chk("err_pop_a", 32'(pop_vc0), 1);
        next();
        fifo_error_any = 1'b1;
        #1;
        chk("err_pre_state", 32'(state), 3);
        chk("err_pre_push0", 32'(push_d0), 1);
        chk("err_pre_data0", 32'(data_d0), 32'h06);
        next();
        fifo_error_any = 1'b0;
        #1;
        chk("err_state", 32'(state), 4);
        chk("err_drop_push0", 32'(push_d0), 0);
        chk("err_drop_data0", 32'(data_d0), 0);
        chk("err_nopop", 32'(pop_vc0), 0);
        chk("err_pkt", 32'(pkt_count), 8);
        next();
        chk("err_sticky", 32'(state), 4);
        chk("err_sticky_nopop", 32'(pop_vc0), 0);
        init = 1'b1;
        next();
        chk("err_to_init", 32'(state), 1);
        init = 1'b0;
        next();
        chk("err_init_idle", 32'(state), 2);
        chk("err_init_pkt", 32'(pkt_count), 0);
        next();
        chk("err_resume_pop", 32'(pop_vc0), 1);
        next();
        chk("err_resume_push0", 32'(push_d0), 1);
        chk("err_resume_data0", 32'(data_d0), 32'h08);
        next();
        chk("err_resume_pkt", 32'(pkt_count), 1);
        next();
        chk("err_resume_idle", 32'(state), 2);

        // ---- Wrap: 257 words to D0 ----
        init = 1'b1;
        next();
        init = 1'b0;
        next();
        chk("wrap_start_pkt", 32'(pkt_count), 0);
        for (int i = 0; i < 257; i++) begin
            load0(6'(i % 16));
        end
        n_d0     = 0;
        n_d1     = 0;
        bad_data = 0;
        exp_i    = 0;
        done     = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            next();
            if (push_d0) begin
                if (data_d0 !== 6'(exp_i % 16)) bad_data++;
                exp_i++;
                n_d0++;
            end
            if (push_d1) n_d1++;
            if (idle) done = 1'b1;
        end
        chk("wrap_done", 32'(done), 1);
        chk("wrap_n_d0", n_d0, 257);
        chk("wrap_n_d1", n_d1, 0);
        chk("wrap_bad_data", bad_data, 0);
        chk("wrap_pkt", 32'(pkt_count), 1);

        // ---- Asynchronous reset mid-traffic ----
        load0(6'h19);
        load0(6'h0A);
        next();
        chk("ar_pop", 32'(pop_vc0), 1);
        next();
        chk("ar_pre_push1", 32'(push_d1), 1);
        reset_L = 1'b0;
        #1;
        chk("ar_state", 32'(state), 0);
        chk("ar_push1", 32'(push_d1), 0);
        chk("ar_data1", 32'(data_d1), 0);
        chk("ar_pop0", 32'(pop_vc0), 0);
        chk("ar_idle", 32'(idle), 0);
        chk("ar_pkt", 32'(pkt_count), 0);
        next();
        reset_L = 1'b1;
        next();
        chk("ar_rel_init", 32'(state), 1);
        next();
        chk("ar_rel_idle", 32'(state), 2);
        chk("ar_rel_idle_flag", 32'(idle), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
